// File: rtl/axi_read_arbiter.sv
// Shares one AXI4 read channel between the instruction-fetch and data-cache requesters.
// One burst is in flight at a time; ties are broken round-robin and R beats are steered by rid.
module axi_read_arbiter #(
  parameter int         DATA_WIDTH = 32,
  parameter logic [3:0] INST_ID    = 4'd0,
  parameter logic [3:0] DATA_ID    = 4'd1
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  inst_req_valid,
  output logic                  inst_req_ready,
  input  logic [31:0]           inst_req_addr,
  input  logic [7:0]            inst_req_len,
  input  logic [2:0]            inst_req_size,
  output logic                  inst_rsp_valid,
  output logic [DATA_WIDTH-1:0] inst_rsp_data,
  output logic [1:0]            inst_rsp_resp,
  output logic                  inst_rsp_last,
  input  logic                  data_req_valid,
  output logic                  data_req_ready,
  input  logic [31:0]           data_req_addr,
  input  logic [7:0]            data_req_len,
  input  logic [2:0]            data_req_size,
  output logic                  data_rsp_valid,
  output logic [DATA_WIDTH-1:0] data_rsp_data,
  output logic [1:0]            data_rsp_resp,
  output logic                  data_rsp_last,
  output logic [3:0]            arid,
  output logic [31:0]           araddr,
  output logic [7:0]            arlen,
  output logic [2:0]            arsize,
  output logic [1:0]            arburst,
  output logic [1:0]            arlock,
  output logic [3:0]            arcache,
  output logic [2:0]            arprot,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [3:0]            rid,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [1:0]            rresp,
  input  logic                  rlast,
  input  logic                  rvalid,
  output logic                  rready,
  output logic [1:0]            dbg_state_o
);

  // Handshakes: a transfer happens on a rising edge where valid && ready; a raised
  // valid (arvalid, *_req_valid) is held with a stable payload until that edge.
  typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2} state_t;

  state_t      state_q, state_d;
  logic        last_grant_q;  // 1 = data side won the previous grant
  logic        grant_q;       // 1 = data side owns the current burst
  logic [3:0]  arid_q;
  logic [31:0] araddr_q;
  logic [7:0]  arlen_q;
  logic [2:0]  arsize_q;
  logic        beat_match;

  assign beat_match = rvalid && (rid == arid_q);

  always_comb begin
    state_d        = state_q;
    inst_req_ready = 1'b0;
    data_req_ready = 1'b0;
    arvalid        = 1'b0;
    rready         = 1'b0;
    inst_rsp_valid = 1'b0;
    data_rsp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        // Readies are gated by aresetn so no grant is shown while reset is held.
        if (inst_req_valid && (!data_req_valid || last_grant_q)) begin
          inst_req_ready = aresetn;
          state_d        = ADDR;
        end else if (data_req_valid) begin
          data_req_ready = aresetn;
          state_d        = ADDR;
        end
      end
      ADDR: begin
        arvalid = 1'b1;
        if (arready) state_d = DATA;
      end
      DATA: begin
        rready = 1'b1;
        if (beat_match) begin
          inst_rsp_valid = !grant_q;
          data_rsp_valid = grant_q;
          if (rlast) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      arid_q       <= 4'd0;
      araddr_q     <= 32'd0;
      arlen_q      <= 8'd0;
      arsize_q     <= 3'd0;
    end else begin
      state_q <= state_d;
      if (inst_req_ready) begin
        arid_q       <= INST_ID;
        araddr_q     <= inst_req_addr;
        arlen_q      <= inst_req_len;
        arsize_q     <= inst_req_size;
        grant_q      <= 1'b0;
        last_grant_q <= 1'b0;
      end else if (data_req_ready) begin
        arid_q       <= DATA_ID;
        araddr_q     <= data_req_addr;
        arlen_q      <= data_req_len;
        arsize_q     <= data_req_size;
        grant_q      <= 1'b1;
        last_grant_q <= 1'b1;
      end
    end
  end

  assign arid    = arid_q;
  assign araddr  = araddr_q;
  assign arlen   = arlen_q;
  assign arsize  = arsize_q;
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;

  assign inst_rsp_data = rdata;
  assign inst_rsp_resp = rresp;
  assign inst_rsp_last = inst_rsp_valid && rlast;
  assign data_rsp_data = rdata;
  assign data_rsp_resp = rresp;
  assign data_rsp_last = data_rsp_valid && rlast;

  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed bench for axi_read_arbiter: grants, round-robin, AR stall, rid filtering,
// error responses and mid-burst reset. Inputs change and outputs are sampled around negedge.
module tb_axi_read_arbiter;
  localparam int DW = 32;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic          inst_req_valid, inst_req_ready;
  logic [31:0]   inst_req_addr;
  logic [7:0]    inst_req_len;
  logic [2:0]    inst_req_size;
  logic          inst_rsp_valid, inst_rsp_last;
  logic [DW-1:0] inst_rsp_data;
  logic [1:0]    inst_rsp_resp;
  logic          data_req_valid, data_req_ready;
  logic [31:0]   data_req_addr;
  logic [7:0]    data_req_len;
  logic [2:0]    data_req_size;
  logic          data_rsp_valid, data_rsp_last;
  logic [DW-1:0] data_rsp_data;
  logic [1:0]    data_rsp_resp;
  logic [3:0]    arid;
  logic [31:0]   araddr;
  logic [7:0]    arlen;
  logic [2:0]    arsize;
  logic [1:0]    arburst, arlock;
  logic [3:0]    arcache;
  logic [2:0]    arprot;
  logic          arvalid, arready;
  logic [3:0]    rid;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          rlast, rvalid, rready;
  logic [1:0]    dbg_state_o;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  logic [DW-1:0] exp_q[$];

  axi_read_arbiter #(.DATA_WIDTH(DW), .INST_ID(4'd0), .DATA_ID(4'd1)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .inst_req_valid(inst_req_valid), .inst_req_ready(inst_req_ready),
    .inst_req_addr(inst_req_addr), .inst_req_len(inst_req_len), .inst_req_size(inst_req_size),
    .inst_rsp_valid(inst_rsp_valid), .inst_rsp_data(inst_rsp_data),
    .inst_rsp_resp(inst_rsp_resp), .inst_rsp_last(inst_rsp_last),
    .data_req_valid(data_req_valid), .data_req_ready(data_req_ready),
    .data_req_addr(data_req_addr), .data_req_len(data_req_len), .data_req_size(data_req_size),
    .data_rsp_valid(data_rsp_valid), .data_rsp_data(data_rsp_data),
    .data_rsp_resp(data_rsp_resp), .data_rsp_last(data_rsp_last),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .dbg_state_o(dbg_state_o)
  );

  // Clock / reset
  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(negedge aclk);
  endtask

  // Requester valids are already set by the caller; checks who wins, then drops the winner.
  task automatic grant(input bit exp_data);
    #1;
    check("inst_req_ready", inst_req_ready, 32'(!exp_data));
    check("data_req_ready", data_req_ready, 32'(exp_data));
    step();
    if (exp_data) data_req_valid = 1'b0;
    else inst_req_valid = 1'b0;
  endtask

  task automatic addr_phase(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                            input logic [2:0] size, input int stall);
    for (int k = 0; k <= stall; k++) begin
      arready = (k == stall);
      #1;
      check("arvalid", arvalid, 1);
      check("araddr", araddr, a);
      check("arlen", arlen, 32'(len));
      check("arsize", arsize, 32'(size));
      check("arid", arid, 32'(id));
      check("no_ready_in_addr", 32'({inst_req_ready, data_req_ready}), 0);
      step();
    end
    arready = 1'b0;
    #1;
    check("arvalid_drop", arvalid, 0);
    check("rready_data", rready, 1);
    check("state_data", dbg_state_o, 2);
  endtask

  task automatic beat(input bit to_data, input logic [3:0] id, input bit last, input bit match,
                      input logic [1:0] resp, input logic [31:0] d);
    logic [31:0] exp_d;
    rvalid = 1'b1; rid = id; rdata = d; rresp = resp; rlast = last;
    if (match) exp_q.push_back(d);
    #1;
    check("rready", rready, 1);
    if (match) begin
      exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
      check("rsp_valid", to_data ? data_rsp_valid : inst_rsp_valid, 1);
      check("other_rsp_valid", to_data ? inst_rsp_valid : data_rsp_valid, 0);
      check("rsp_data", to_data ? data_rsp_data : inst_rsp_data, exp_d);
      check("rsp_resp", to_data ? data_rsp_resp : inst_rsp_resp, 32'(resp));
      check("rsp_last", to_data ? data_rsp_last : inst_rsp_last, 32'(last));
    end else begin
      check("swallow_valid", 32'({inst_rsp_valid, data_rsp_valid}), 0);
    end
    step();
    rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
  endtask

  task automatic burst(input bit to_data, input logic [3:0] id, input int n);
    for (int i = 0; i < n; i++)
      beat(to_data, id, i == n - 1, 1'b1, 2'b00, 32'hA000_0000 + (32'(id) << 16) + 32'(i));
    #1;
    check("state_idle_after_burst", dbg_state_o, 0);
  endtask

  initial begin
    aresetn = 1'b0;
    inst_req_valid = 1'b1; inst_req_addr = 32'h1C00_0000; inst_req_len = 8'd3; inst_req_size = 3'd2;
    data_req_valid = 1'b1; data_req_addr = 32'h8000_0040; data_req_len = 8'd1; data_req_size = 3'd2;
    arready = 1'b0; rid = 4'd0; rdata = '0; rresp = 2'b00; rlast = 1'b0; rvalid = 1'b0;
    step();
    #1;
    check("rst_ready", 32'({inst_req_ready, data_req_ready}), 0);
    check("rst_arvalid", arvalid, 0);
    check("rst_rready", rready, 0);
    check("rst_state", dbg_state_o, 0);
    check("rst_araddr", araddr, 0);
    check("arburst", arburst, 1);
    check("ar_consts", 32'({arlock, arcache, arprot}), 0);
    step();
    aresetn = 1'b1;

    // Tie after reset: inst first, data in the IDLE cycle after inst's rlast
    grant(1'b0);
    addr_phase(4'd0, 32'h1C00_0000, 8'd3, 3'd2, 0);
    burst(1'b0, 4'd0, 4);
    grant(1'b1);
    addr_phase(4'd1, 32'h8000_0040, 8'd1, 3'd2, 0);
    burst(1'b1, 4'd1, 2);

    // Third tie goes back to inst; AR stalls 5 cycles; foreign rid beat is swallowed
    inst_req_valid = 1'b1; inst_req_addr = 32'h1C00_0100; inst_req_len = 8'd1;
    data_req_valid = 1'b1; data_req_addr = 32'h8000_0080; data_req_len = 8'd1;
    grant(1'b0);
    inst_req_addr = 32'hDEAD_BEEF;
    addr_phase(4'd0, 32'h1C00_0100, 8'd1, 3'd2, 5);
    beat(1'b0, 4'd1, 1'b1, 1'b0, 2'b00, 32'h5555_0000);
    #1;
    check("state_after_foreign_last", dbg_state_o, 2);
    burst(1'b0, 4'd0, 2);

    // Data burst with SLVERR on the last beat
    grant(1'b1);
    addr_phase(4'd1, 32'h8000_0080, 8'd1, 3'd2, 0);
    beat(1'b1, 4'd1, 1'b0, 1'b1, 2'b00, 32'h0000_1111);
    beat(1'b1, 4'd1, 1'b1, 1'b1, 2'b10, 32'h0000_2222);
    #1;
    check("state_idle_after_err", dbg_state_o, 0);

    // Reset during beat 2 of a 4-beat data burst
    data_req_valid = 1'b1; data_req_addr = 32'h8000_00C0; data_req_len = 8'd3;
    grant(1'b1);
    addr_phase(4'd1, 32'h8000_00C0, 8'd3, 3'd2, 0);
    beat(1'b1, 4'd1, 1'b0, 1'b1, 2'b00, 32'h0000_3333);
    rvalid = 1'b1; rid = 4'd1; rdata = 32'h0000_4444;
    inst_req_valid = 1'b1; data_req_valid = 1'b1;
    inst_req_addr = 32'h1C00_0200; inst_req_len = 8'd0;
    aresetn = 1'b0;
    #1;
    check("midrst_arvalid", arvalid, 0);
    check("midrst_rready", rready, 0);
    check("midrst_rsp_valid", 32'({inst_rsp_valid, data_rsp_valid}), 0);
    check("midrst_rsp_last", 32'({inst_rsp_last, data_rsp_last}), 0);
    check("midrst_req_ready", 32'({inst_req_ready, data_req_ready}), 0);
    check("midrst_state", dbg_state_o, 0);
    step();
    rvalid = 1'b0;
    aresetn = 1'b1;
    grant(1'b0);
    addr_phase(4'd0, 32'h1C00_0200, 8'd0, 3'd2, 0);
    burst(1'b0, 4'd0, 1);

    check("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/axi_read_arbiter.md
Name: axi_read_arbiter

Overview:
Shares the single AXI4 read channel (AR/R) of the core between the instruction-fetch requester and the data-cache requester. The arbiter keeps at most one read burst in flight. It round-robins between requesters when both are pending and drives the AR channel from registers. Returning R beats are steered to the granted requester. It sits between the core's cache refill logic and the top-level AXI master ports.

Parameters:
DATA_WIDTH, 32, AXI rdata width and requester response data width
INST_ID, 4'd0, arid value used for instruction-side bursts
DATA_ID, 4'd1, arid value used for data-side bursts

Ports:
aclk  in  1  clock
aresetn  in  1  reset
inst_req_valid  in  1  instruction read request pending
inst_req_ready  out  1  instruction request accepted (grant pulse)
inst_req_addr  in  32  instruction burst start address
inst_req_len  in  8  instruction burst length minus 1 (AXI arlen encoding)
inst_req_size  in  3  instruction beat size (AXI arsize encoding)
inst_rsp_valid  out  1  instruction response beat valid
inst_rsp_data  out  DATA_WIDTH  instruction response beat data
inst_rsp_resp  out  2  instruction response beat rresp
inst_rsp_last  out  1  last instruction response beat
data_req_valid/ready/addr/len/size  same as inst_*  data-side request
data_rsp_valid/data/resp/last  same as inst_*  data-side response
arid  out  4  AXI read address ID
araddr  out  32  AXI read address
arlen  out  8  AXI burst length
arsize  out  3  AXI beat size
arburst  out  2  AXI burst type
arlock  out  2  AXI lock
arcache  out  4  AXI cache attributes
arprot  out  3  AXI protection
arvalid  out  1  AXI read address valid
arready  in  1  AXI read address ready
rid  in  4  AXI read data ID
rdata  in  DATA_WIDTH  AXI read data
rresp  in  2  AXI read response
rlast  in  1  AXI last read beat
rvalid  in  1  AXI read data valid
rready  out  1  AXI read data ready

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (aresetn).
  - Asserting aresetn low clears state to IDLE and clears last_grant to DATA.
  - While reset is asserted, arvalid=0, rready=0, every *_req_ready=0, every *_rsp_valid=0, *_rsp_last=0.
  - AR payload registers reset to 0.
- Constant outputs: arburst=2'b01 (INCR), arlock=0, arcache=0, arprot=0.
- FSM states: IDLE, ADDR, DATA.
- IDLE:
  - With no request pending, stay in IDLE.
  - When at least one *_req_valid is high, grant combinationally in the same cycle and pulse the winner's *_req_ready for exactly 1 cycle.
  - On the grant edge: latch addr/len/size into the AR registers, set arid to INST_ID or DATA_ID, record grant and last_grant, then go to ADDR.
- Round-robin: when both requesters are valid, grant the one that is NOT last_grant. After reset, last_grant=DATA, so inst wins the first tie.
- ADDR:
  - arvalid=1; araddr/arlen/arsize/arid are stable until the handshake.
  - On arvalid&&arready, go to DATA. arvalid drops in the next cycle.
  - arvalid is never withdrawn once raised.
- DATA:
  - rready=1.
  - A beat is taken when rvalid&&rready.
  - If rid==arid, forward the beat combinationally to the granted requester: *_rsp_valid=1, data=rdata, resp=rresp, last=rlast. The other requester's rsp_valid stays 0.
  - If rid!=arid, accept and discard the beat with no rsp_valid, and do not end the burst on its rlast.
  - On a matching beat with rlast=1, go to IDLE.
  - rresp errors (SLVERR/DECERR) are forwarded and the burst continues to rlast.
- Latency:
  - Grant to arvalid: 1 cycle.
  - R beat to rsp: 0 cycles (combinational).
  - After the last beat, the next grant can occur 1 cycle later (IDLE cycle), so there is one bubble between bursts.
- Requests arriving while not in IDLE see req_ready=0 and must hold valid. The address is sampled only at grant.
- Asserting reset mid-burst aborts the burst with no partial state kept; the interconnect shares aresetn.

Test Plan:
- Single inst request (addr=0x1C000000, len=3, size=2) with arready immediate → inst_req_ready pulses at cycle 0; arvalid, araddr=0x1C000000, arlen=3, arid=0 at cycle 1; four beats appear on inst_rsp with last on the 4th; FSM is back in IDLE after the 4th beat.
- Both valid in the same cycle after reset → inst granted first; data (arid=1) granted in the IDLE cycle after inst's rlast; a third simultaneous pair alternates back to inst.
- arready held low for 5 cycles during ADDR → arvalid stays 1 with constant payload for 6 cycles; no req_ready pulse occurs meanwhile.
- Beat with rid=1 injected while an inst burst (arid=0) is active → beat is swallowed with no rsp_valid on either side; the burst still ends only on the matching rid=0 rlast.
- rresp=2'b10 on beat 2 of a data burst (len=1) → data_rsp_resp=2 on that beat with data_rsp_last=1; FSM returns to IDLE.
- aresetn pulled low during DATA beat 2 of 4 → arvalid=0, rready=0, rsp_valid=0 immediately; after release, a new request is granted normally with inst winning the tie.
